// File: rtl/stim_misr_harness.sv
// Seeded stimulus generator and 32-bit MISR response compactor for fuzzed DUT netlists.
// Each vector is held for DUT_LAT+1 cycles; dut_out is folded into the signature on the last edge.
module stim_misr_harness #(
    parameter int unsigned IN_W    = 50,
    parameter int unsigned OUT_W   = 867,
    parameter int unsigned DUT_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              step_mode_i,
    input  logic              step_i,
    input  logic [63:0]       seed_i,
    input  logic [15:0]       num_vec_i,
    input  logic [31:0]       expected_sig_i,
    input  logic [OUT_W-1:0]  dut_out_i,
    output logic [IN_W-1:0]   dut_in_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [15:0]       vec_idx_o,
    output logic [31:0]       signature_o,
    output logic              match_o
);

    localparam int unsigned LFSR_W = 64;
    localparam int unsigned SIG_W  = 32;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned IDX_W  = 16;
    localparam int unsigned REPS   = (IN_W + LFSR_W - 1) / LFSR_W;
    localparam int unsigned NSLICE = (OUT_W + SIG_W - 1) / SIG_W;
    localparam int unsigned PAD_W  = NSLICE * SIG_W;

    localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
    localparam logic [SIG_W-1:0]  MISR_POLY = 32'h04C1_1DB7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             state_q;
    logic [LFSR_W-1:0]  lfsr_q;
    logic [LFSR_W-1:0]  lfsr_d;
    logic [SIG_W-1:0]   sig_q;
    logic [SIG_W-1:0]   sig_d;
    logic [IDX_W-1:0]   vec_idx_q;
    logic [IDX_W-1:0]   vec_idx_d;
    logic [IDX_W-1:0]   num_vec_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               step_mode_q;
    logic               busy_q;
    logic               done_q;

    logic [REPS*LFSR_W-1:0] lfsr_rep;
    logic [PAD_W-1:0]       out_pad;
    logic [SIG_W-1:0]       fold;

    // Stimulus: LFSR tiled across the DUT input width
    assign lfsr_rep = {REPS{lfsr_q}};
    assign dut_in_o = lfsr_rep[IN_W-1:0];

    // Response fold: XOR of all 32-bit slices, top partial slice zero-extended
    assign out_pad = PAD_W'(dut_out_i);

    always_comb begin
        fold = '0;
        for (int i = 0; i < int'(NSLICE); i++) begin
            fold = fold ^ out_pad[i*SIG_W +: SIG_W];
        end
    end

    assign lfsr_d    = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    assign sig_d     = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? MISR_POLY : '0) ^ fold;
    assign vec_idx_d = vec_idx_q + IDX_W'(1);

    // Run controller: start/settle/capture/hold sequencing
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            lfsr_q      <= '0;
            sig_q       <= '0;
            vec_idx_q   <= '0;
            num_vec_q   <= '0;
            cnt_q       <= '0;
            step_mode_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        lfsr_q      <= (seed_i == '0) ? LFSR_W'(1) : seed_i;
                        sig_q       <= '0;
                        vec_idx_q   <= '0;
                        cnt_q       <= CNT_W'(DUT_LAT);
                        num_vec_q   <= num_vec_i;
                        step_mode_q <= step_mode_i;
                        if (num_vec_i == '0) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_SETTLE;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                S_SETTLE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        // Capture edge: last cycle of this vector's presentation
                        sig_q     <= sig_d;
                        vec_idx_q <= vec_idx_d;
                        lfsr_q    <= lfsr_d;
                        cnt_q     <= CNT_W'(DUT_LAT);
                        if (vec_idx_d == num_vec_q) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (step_mode_q) begin
                            state_q <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (step_i) begin
                        state_q <= S_SETTLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign vec_idx_o   = vec_idx_q;
    assign signature_o = sig_q;
    assign match_o     = done_q && (sig_q == expected_sig_i);

endmodule

// File: tb/tb_stim_misr_harness.sv
// Scoreboard bench for stim_misr_harness: two lanes with DUT_LAT 0 and 3, each driven by a fake DUT.
module tb_stim_misr_harness;

    localparam int unsigned IN_W  = 50;
    localparam int unsigned OUT_W = 867;
    localparam int unsigned REP_O = (OUT_W + IN_W - 1) / IN_W;

    typedef struct {
        logic [IN_W-1:0] din;
        logic [31:0]     sig;
    } exp_t;

    logic clk;

    logic              rst_r   [2];
    logic              start_r [2];
    logic              sm_r    [2];
    logic              step_r  [2];
    logic [63:0]       seed_r  [2];
    logic [15:0]       nv_r    [2];
    logic [31:0]       es_r    [2];
    int                omode   [2];
    logic [OUT_W-1:0]  dout    [2];
    logic [IN_W-1:0]   din     [2];
    logic              busy_w  [2];
    logic              done_w  [2];
    logic              match_w [2];
    logic [15:0]       idx_w   [2];
    logic [31:0]       sig_w   [2];

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Fake DUT response: 0 = zeros, 1 = all ones, 2 = dut_in tiled across the output
    function automatic logic [OUT_W-1:0] mk_out(input logic [IN_W-1:0] d, input int m);
        logic [REP_O*IN_W-1:0] r;
        r = {REP_O{d}};
        if (m == 0) return '0;
        if (m == 1) return '1;
        return r[OUT_W-1:0];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_lane
        stim_misr_harness #(
            .IN_W    (IN_W),
            .OUT_W   (OUT_W),
            .DUT_LAT ((g == 0) ? 0 : 3)
        ) u_dut (
            .clk_i          (clk),
            .rst_i          (rst_r[g]),
            .start_i        (start_r[g]),
            .step_mode_i    (sm_r[g]),
            .step_i         (step_r[g]),
            .seed_i         (seed_r[g]),
            .num_vec_i      (nv_r[g]),
            .expected_sig_i (es_r[g]),
            .dut_out_i      (dout[g]),
            .dut_in_o       (din[g]),
            .busy_o         (busy_w[g]),
            .done_o         (done_w[g]),
            .vec_idx_o      (idx_w[g]),
            .signature_o    (sig_w[g]),
            .match_o        (match_w[g])
        );
        assign dout[g] = mk_out(din[g], omode[g]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    function automatic logic [63:0] lfsr_next(input logic [63:0] l);
        return (l >> 1) ^ (l[0] ? 64'hD800_0000_0000_0000 : 64'h0);
    endfunction

    function automatic logic [IN_W-1:0] din_of(input logic [63:0] l);
        logic [127:0] r;
        r = {l, l};
        return r[IN_W-1:0];
    endfunction

    function automatic logic [31:0] fold_of(input logic [OUT_W-1:0] d);
        logic [895:0] p;
        logic [31:0]  f;
        p = '0;
        p[OUT_W-1:0] = d;
        f = '0;
        for (int i = 0; i < 28; i++) f = f ^ p[i*32 +: 32];
        return f;
    endfunction

    function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] f);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0) ^ f;
    endfunction

    function automatic logic [31:0] model_sig(input logic [63:0] sd, input logic [15:0] nv, input int m);
        logic [63:0] l;
        logic [31:0] s;
        l = (sd == 64'h0) ? 64'h1 : sd;
        s = '0;
        for (int k = 0; k < int'(nv); k++) begin
            s = misr(s, fold_of(mk_out(din_of(l), m)));
            l = lfsr_next(l);
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset(input int u);
        check("rst_din",   64'(din[u]),     64'h0);
        check("rst_sig",   64'(sig_w[u]),   64'h0);
        check("rst_idx",   64'(idx_w[u]),   64'h0);
        check("rst_busy",  64'(busy_w[u]),  64'h0);
        check("rst_done",  64'(done_w[u]),  64'h0);
        check("rst_match", 64'(match_w[u]), 64'h0);
    endtask

    // One run on lane u: push expected per-vector stimulus/signature, then pop at each capture edge
    task automatic run(input int u, input logic [63:0] sd, input logic [15:0] nv,
                       input logic sm, input int m, input logic [31:0] es);
        int          lat;
        logic [63:0] l;
        logic [31:0] s;
        exp_t        e;
        lat = (u == 0) ? 0 : 3;
        l = (sd == 64'h0) ? 64'h1 : sd;
        s = '0;
        for (int k = 0; k < int'(nv); k++) begin
            e.din = din_of(l);
            s     = misr(s, fold_of(mk_out(e.din, m)));
            e.sig = s;
            q.push_back(e);
            l = lfsr_next(l);
        end
        seed_r[u] = sd; nv_r[u] = nv; sm_r[u] = sm; omode[u] = m; es_r[u] = es;
        start_r[u] = 1'b1;
        step_r[u]  = sm;
        @(posedge clk); #1;
        start_r[u] = 1'b0;
        step_r[u]  = 1'b0;
        for (int k = 0; k < int'(nv); k++) begin
            if (k > 0 && sm) begin
                check("hold_idx", 64'(idx_w[u]), 64'(k));
                for (int i = 0; i < 10; i++) begin
                    start_r[u] = (i == 4);
                    @(posedge clk); #1;
                    start_r[u] = 1'b0;
                    check("hold_din", 64'(din[u]), 64'(q[0].din));
                    check("hold_busy", 64'(busy_w[u]), 64'h1);
                end
                check("hold_idx2", 64'(idx_w[u]), 64'(k));
                step_r[u] = 1'b1;
                @(posedge clk); #1;
                step_r[u] = 1'b0;
            end
            for (int j = 0; j <= lat; j++) begin
                check("din",  64'(din[u]),    64'(q[0].din));
                check("busy", 64'(busy_w[u]), 64'h1);
                check("done_early", 64'(done_w[u]), 64'h0);
                @(posedge clk); #1;
            end
            e = q.pop_front();
            check("idx", 64'(idx_w[u]), 64'(k + 1));
            check("sig", 64'(sig_w[u]), 64'(e.sig));
        end
        check("done",  64'(done_w[u]),  64'h1);
        check("busy_end", 64'(busy_w[u]), 64'h0);
        check("final_sig", 64'(sig_w[u]), 64'(s));
        check("match", 64'(match_w[u]), 64'(s == es));
        @(posedge clk); #1;
        check("done_level", 64'(done_w[u]), 64'h1);
        check("sig_frozen", 64'(sig_w[u]),  64'(s));
    endtask

    initial begin
        logic [63:0] sd;
        for (int u = 0; u < 2; u++) begin
            rst_r[u] = 1'b1; start_r[u] = 1'b0; sm_r[u] = 1'b0; step_r[u] = 1'b0;
            seed_r[u] = '0; nv_r[u] = '0; es_r[u] = '0; omode[u] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_r[0] = 1'b0;
        rst_r[1] = 1'b0;
        check_reset(0);
        check_reset(1);

        // Zero-length run
        run(0, 64'h5, 16'd0, 1'b0, 1, 32'h0);

        // seed 0 -> LFSR 1, dut_out zero keeps signature 0
        run(0, 64'h0, 16'd3, 1'b0, 0, 32'h0);

        // All-ones response
        run(0, 64'h0, 16'd2, 1'b0, 1, 32'h04C1_1DBF);
        check("ones_sig", 64'(sig_w[0]), 64'h04C1_1DBF);
        es_r[0] = 32'h04C1_1DBE;
        #1;
        check("ones_match_neg", 64'(match_w[0]), 64'h0);

        // Free-run with latency 3
        sd = {$urandom(), $urandom()};
        run(1, sd, 16'd4, 1'b0, 2, model_sig(sd, 16'd4, 2));

        // Step mode on both lanes
        run(1, 64'hDEAD_BEEF_0123_4567, 16'd2, 1'b1, 2, 32'h1234_5678);
        run(0, 64'hCAFE_F00D_0000_0001, 16'd3, 1'b1, 2,
            model_sig(64'hCAFE_F00D_0000_0001, 16'd3, 2));

        // Longer free-run
        sd = {$urandom(), $urandom()};
        run(0, sd, 16'd20, 1'b0, 2, model_sig(sd, 16'd20, 2));

        // Reset mid-run, then rerun with the same seed
        sd = 64'h1234_5678_9ABC_DEF0;
        seed_r[1] = sd; nv_r[1] = 16'd5; sm_r[1] = 1'b0; omode[1] = 2; es_r[1] = 32'h0;
        start_r[1] = 1'b1;
        @(posedge clk); #1;
        start_r[1] = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("mid_busy", 64'(busy_w[1]), 64'h1);
        rst_r[1] = 1'b1;
        @(posedge clk); #1;
        rst_r[1] = 1'b0;
        check_reset(1);
        run(1, sd, 16'd5, 1'b0, 2, model_sig(sd, 16'd5, 2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
